// File: rtl/tdes_stream_if.sv
// rtl/tdes_stream_if.sv - host-side input stream, output stream and key write port of tdes_stream_ctrl
interface tdes_stream_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic        in_mode;

    logic        key_wr;
    logic [2:0]  key_addr;
    logic [31:0] key_data;
    logic        key_err;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;

    modport master (
        output in_valid, in_word, in_mode, key_wr, key_addr, key_data, out_ready,
        input  in_ready, key_err, out_valid, out_word
    );

    modport slave (
        input  in_valid, in_word, in_mode, key_wr, key_addr, key_data, out_ready,
        output in_ready, key_err, out_valid, out_word
    );
endinterface

// File: rtl/tdes_stream_ctrl.sv
// rtl/tdes_stream_ctrl.sv - word-stream initiator for triple_DES_block: assembles a block, runs it, returns the result
module tdes_stream_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic              clk,
    input  logic              nrst,
    tdes_stream_if.slave      bus,
    output logic              tdes_enable,
    output logic              tdes_encr_decr,
    output logic [63:0]       tdes_data,
    output logic [63:0]       tdes_key1,
    output logic [63:0]       tdes_key2,
    output logic [63:0]       tdes_key3,
    input  logic              tdes_done,
    input  logic [63:0]       tdes_result,
    output logic              busy,
    output logic              timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOW,
        S_START,
        S_WAIT,
        S_OUT_HI,
        S_OUT_LO
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t             state_q;
    logic [63:0]        data_q;
    logic [63:0]        result_q;
    logic [63:0]        key1_q;
    logic [63:0]        key2_q;
    logic [63:0]        key3_q;
    logic               mode_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               enable_q;
    logic               key_err_q;
    logic               in_hs_d;
    logic               expire_d;

    assign in_hs_d  = bus.in_valid && ((state_q == S_IDLE) || (state_q == S_LOW));
    // done in the final WAIT cycle takes priority over the timeout
    assign expire_d = (state_q == S_WAIT) && (cnt_q == CNT_LAST) && !tdes_done;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= S_IDLE;
            data_q    <= '0;
            result_q  <= '0;
            key1_q    <= '0;
            key2_q    <= '0;
            key3_q    <= '0;
            mode_q    <= 1'b0;
            cnt_q     <= '0;
            enable_q  <= 1'b0;
            key_err_q <= 1'b0;
        end else begin
            enable_q  <= 1'b0;
            key_err_q <= 1'b0;

            // key writes land only while idle, which includes the hi-word handshake cycle
            if (bus.key_wr) begin
                if ((state_q == S_IDLE) && (bus.key_addr <= 3'd5)) begin
                    case (bus.key_addr)
                        3'd0:    key1_q[63:32] <= bus.key_data;
                        3'd1:    key1_q[31:0]  <= bus.key_data;
                        3'd2:    key2_q[63:32] <= bus.key_data;
                        3'd3:    key2_q[31:0]  <= bus.key_data;
                        3'd4:    key3_q[63:32] <= bus.key_data;
                        default: key3_q[31:0]  <= bus.key_data;
                    endcase
                end else begin
                    key_err_q <= 1'b1;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (in_hs_d) begin
                        data_q[63:32] <= bus.in_word;
                        mode_q        <= bus.in_mode;
                        state_q       <= S_LOW;
                    end
                end
                S_LOW: begin
                    if (in_hs_d) begin
                        data_q[31:0] <= bus.in_word;
                        enable_q     <= 1'b1;
                        state_q      <= S_START;
                    end
                end
                S_START: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (tdes_done) begin
                        result_q <= tdes_result;
                        state_q  <= S_OUT_HI;
                    end else if (expire_d) begin
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_OUT_HI: begin
                    if (bus.out_ready) begin
                        state_q <= S_OUT_LO;
                    end
                end
                S_OUT_LO: begin
                    if (bus.out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready   = (state_q == S_IDLE) || (state_q == S_LOW);
    assign bus.out_valid  = (state_q == S_OUT_HI) || (state_q == S_OUT_LO);
    assign bus.out_word   = (state_q == S_OUT_HI) ? result_q[63:32] : result_q[31:0];
    assign bus.key_err    = key_err_q;

    assign tdes_enable    = enable_q;
    assign tdes_encr_decr = mode_q;
    assign tdes_data      = data_q;
    assign tdes_key1      = key1_q;
    assign tdes_key2      = key2_q;
    assign tdes_key3      = key3_q;
    assign busy           = (state_q != S_IDLE);
    assign timeout_err    = expire_d;

endmodule

// File: tb/tb_tdes_stream_ctrl.sv
// tb/tb_tdes_stream_ctrl.sv - scoreboard bench for tdes_stream_ctrl with a cipher stub
module tb_tdes_stream_ctrl;
    localparam int T = 64;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    tdes_stream_if bus();
    logic        tdes_enable, tdes_encr_decr, tdes_done, busy, timeout_err;
    logic [63:0] tdes_data, k1, k2, k3, tdes_result;

    // stub cipher: result = block ^ key1
    assign tdes_result = tdes_data ^ k1;

    tdes_stream_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(7)) dut (
        .clk(clk), .nrst(nrst), .bus(bus),
        .tdes_enable(tdes_enable), .tdes_encr_decr(tdes_encr_decr), .tdes_data(tdes_data),
        .tdes_key1(k1), .tdes_key2(k2), .tdes_key3(k3),
        .tdes_done(tdes_done), .tdes_result(tdes_result),
        .busy(busy), .timeout_err(timeout_err)
    );

    int nchk = 0;
    int nerr = 0;
    logic [63:0] key_m [3];
    logic [31:0] exp_q [$];
    logic [63:0] blk_q [$];
    logic        mode_q [$];
    int  stub_delay = 5;
    int  rdy_mode = 1;
    int  cyc = 0;
    int  n_en = 0;
    int  en_cyc = 0;
    int  n_to = 0;
    bit  expect_to = 0;
    bit  prev_en = 0;
    bit  held = 0;
    logic [31:0] held_word;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        nchk++;
        nerr++;
        $display("FAIL %s: bound expired", name);
    endtask

    always @(posedge clk) cyc++;

    initial begin
        tdes_done = 1'b0;
        forever begin
            @(negedge clk);
            if (tdes_enable && stub_delay != 0) begin
                repeat (stub_delay) @(posedge clk);
                #1 tdes_done = 1'b1;
                @(posedge clk);
                #1 tdes_done = 1'b0;
            end
        end
    end

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.out_ready = 1'b0;
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // monitor: enables, timeouts and output words against the scoreboard
    always @(negedge clk) begin
        if (!nrst) begin
            held = 0;
            prev_en = 0;
        end else begin
            if (tdes_enable) begin
                n_en++;
                en_cyc = cyc;
                check("enable_single_cycle", 64'(prev_en), 64'd0);
                if (blk_q.size() == 0) fail_now("enable_unexpected");
                else begin
                    check("tdes_data", tdes_data, blk_q.pop_front());
                    check("tdes_encr_decr", 64'(tdes_encr_decr), 64'(mode_q.pop_front()));
                end
            end
            prev_en = tdes_enable;
            if (timeout_err) begin
                n_to++;
                check("timeout_expected", 64'(expect_to), 64'd1);
                check("timeout_latency", 64'(cyc - en_cyc), 64'(T));
            end
            if (bus.out_valid) begin
                if (held) check("out_word_stable", 64'(bus.out_word), 64'(held_word));
                if (bus.out_ready) begin
                    held = 0;
                    if (exp_q.size() == 0) fail_now("out_word_unexpected");
                    else check("out_word", 64'(bus.out_word), 64'(exp_q.pop_front()));
                end else begin
                    held = 1;
                    held_word = bus.out_word;
                end
            end else begin
                held = 0;
            end
        end
    end

    task automatic send_word(input logic [31:0] w, input logic m);
        bit hs = 0;
        bus.in_valid = 1'b1;
        bus.in_word = w;
        bus.in_mode = m;
        for (int i = 0; i < 200 && !hs; i++) begin
            @(negedge clk);
            hs = bus.in_ready;
            @(posedge clk);
            #1;
        end
        if (!hs) fail_now("in_handshake");
    endtask

    task automatic push_block(input logic [63:0] blk, input logic m, input bit expect_out);
        logic [63:0] r;
        blk_q.push_back(blk);
        mode_q.push_back(m);
        if (expect_out) begin
            r = blk ^ key_m[0];
            exp_q.push_back(r[63:32]);
            exp_q.push_back(r[31:0]);
        end
    endtask

    task automatic send_block(input logic [63:0] blk, input logic m, input bit expect_out);
        push_block(blk, m, expect_out);
        send_word(blk[63:32], m);
        send_word(blk[31:0], 1'($urandom_range(0, 1)));
    endtask

    task automatic drain();
        bit ok = 0;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            ok = !busy && (exp_q.size() == 0);
        end
        if (!ok) fail_now("drain");
        @(posedge clk);
        #1;
    endtask

    task automatic wait_enable();
        int n0 = n_en;
        bit ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = (n_en != n0);
        end
        if (!ok) fail_now("wait_enable");
    endtask

    task automatic check_keys(input string name);
        check({name, "_key1"}, k1, key_m[0]);
        check({name, "_key2"}, k2, key_m[1]);
        check({name, "_key3"}, k3, key_m[2]);
    endtask

    task automatic key_write(input logic [2:0] a, input logic [31:0] d, input bit exp_err);
        bus.key_wr = 1'b1;
        bus.key_addr = a;
        bus.key_data = d;
        if (!exp_err) begin
            if (a[0]) key_m[a/2][31:0] = d;
            else      key_m[a/2][63:32] = d;
        end
        @(posedge clk);
        #1 bus.key_wr = 1'b0;
        @(negedge clk);
        check("key_err", 64'(bus.key_err), 64'(exp_err));
        check_keys("key_write");
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n0;
        int t0;
        logic [63:0] blk;
        for (int i = 0; i < 3; i++) key_m[i] = '0;
        bus.in_valid = 1'b0;
        bus.in_word = '0;
        bus.in_mode = 1'b0;
        bus.key_wr = 1'b0;
        bus.key_addr = '0;
        bus.key_data = '0;

        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_enable", 64'(tdes_enable), 64'd0);
        check("rst_key_err", 64'(bus.key_err), 64'd0);
        check("rst_timeout", 64'(timeout_err), 64'd0);
        check("rst_data", tdes_data, 64'd0);
        check("rst_mode", 64'(tdes_encr_decr), 64'd0);
        check_keys("rst");
        @(posedge clk);
        #1 nrst = 1'b1;
        @(posedge clk);
        #1;

        // basic block
        key_write(3'd0, 32'h0133_4577, 1'b0);
        key_write(3'd1, 32'h99BB_CDFF, 1'b0);
        n0 = n_en;
        send_block(64'h0123_4567_89AB_CDEF, 1'b1, 1'b1);
        drain();
        check("t1_enable_count", 64'(n_en - n0), 64'd1);

        // output back-pressure
        rdy_mode = 0;
        n0 = n_en;
        send_block({$urandom, $urandom}, 1'b0, 1'b1);
        bus.in_valid = 1'b0;
        t0 = 0;
        while (!bus.out_valid && t0 < 50) begin
            @(negedge clk);
            t0++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_out_valid", 64'(bus.out_valid), 64'd1);
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
        end
        check("bp_enable_count", 64'(n_en - n0), 64'd1);
        rdy_mode = 1;
        drain();

        // timeout with no done
        stub_delay = 0;
        expect_to = 1;
        n0 = n_to;
        send_block({$urandom, $urandom}, 1'b1, 1'b0);
        drain();
        check("to_count", 64'(n_to - n0), 64'd1);
        check("to_in_ready", 64'(bus.in_ready), 64'd1);
        check("to_out_valid", 64'(bus.out_valid), 64'd0);
        expect_to = 0;

        // key writes while busy and with bad address
        stub_delay = 20;
        send_block({$urandom, $urandom}, 1'b0, 1'b1);
        bus.in_valid = 1'b0;
        wait_enable();
        @(posedge clk);
        #1;
        key_write(3'd0, $urandom, 1'b1);
        key_write(3'd5, $urandom, 1'b1);
        drain();
        stub_delay = 5;
        key_write(3'd6, $urandom, 1'b1);
        key_write(3'd7, $urandom, 1'b1);
        for (int a = 2; a < 6; a++) key_write(3'(a), $urandom, 1'b0);

        // key write in the hi-word handshake cycle is accepted
        blk = {$urandom, $urandom};
        bus.key_wr = 1'b1;
        bus.key_addr = 3'd1;
        bus.key_data = $urandom;
        key_m[0][31:0] = bus.key_data;
        push_block(blk, 1'b1, 1'b1);
        send_word(blk[63:32], 1'b1);
        bus.key_wr = 1'b0;
        check("hs_key_err", 64'(bus.key_err), 64'd0);
        send_word(blk[31:0], 1'b0);
        drain();
        check_keys("hs");

        // reset in WAIT, late done ignored
        stub_delay = 8;
        send_block({$urandom, $urandom}, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        wait_enable();
        repeat (3) @(posedge clk);
        #3 nrst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) key_m[i] = '0;
        check("mr_busy", 64'(busy), 64'd0);
        check("mr_in_ready", 64'(bus.in_ready), 64'd1);
        check_keys("mr");
        @(posedge clk);
        #1 nrst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("mr_no_out", 64'(bus.out_valid), 64'd0);
            check("mr_idle", 64'(busy), 64'd0);
        end
        stub_delay = 5;
        key_write(3'd0, $urandom, 1'b0);
        key_write(3'd1, $urandom, 1'b0);

        // done in the last WAIT cycle beats the timeout
        stub_delay = T;
        n0 = n_to;
        send_block({$urandom, $urandom}, 1'b1, 1'b1);
        drain();
        check("late_done_no_timeout", 64'(n_to - n0), 64'd0);

        // randomized traffic
        rdy_mode = 2;
        for (int b = 0; b < 20; b++) begin
            stub_delay = $urandom_range(1, 10);
            send_block({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b1);
            if ($urandom_range(0, 1) == 1) begin
                bus.in_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
            if (b % 5 == 4) begin
                drain();
                key_write(3'($urandom_range(0, 1)), $urandom, 1'b0);
            end
        end
        drain();

        // back-to-back with in_valid and out_ready held high
        rdy_mode = 1;
        stub_delay = 5;
        n0 = n_en;
        for (int b = 0; b < 8; b++) send_block({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b1);
        drain();
        check("b2b_enable_count", 64'(n_en - n0), 64'd8);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        check("blocks_consumed", 64'(blk_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
